// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out transmitter with valid/ready input,
// a one-word holding buffer for gapless streaming, and registered framing
// strobes (frame / sof / eof) aligned with each serial bit on Dout.
//
// Handshake: a word is accepted on a rising edge where in_valid && in_ready.
// in_ready depends only on the holding buffer (never on in_valid), and a
// sender that sees in_ready low must keep its word stable on Din.
module piso_serializer #(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] Din,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         Dout,
  output logic         frame,
  output logic         sof,
  output logic         eof
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        state, state_n;
  logic [N-1:0]  sr, sr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [N-1:0]  hold_data, hold_data_n;
  logic          hold_valid, hold_valid_n;
  logic          dout_n, frame_n, sof_n, eof_n;
  logic          accept;
  logic [N-1:0]  sr_shifted;

  // The buffer is the only thing that can refuse a word.
  assign in_ready = !hold_valid;
  assign accept   = in_valid && in_ready;

  // Move the next bit into the head position.
  always_comb begin
    sr_shifted = '0;
    if (MSB_FIRST) sr_shifted = {sr[N-2:0], 1'b0};
    else           sr_shifted = {1'b0, sr[N-1:1]};
  end

  // Next-state logic: load, shift, buffer, and last-bit word selection.
  always_comb begin
    state_n      = state;
    sr_n         = sr;
    cnt_n        = cnt;
    hold_data_n  = hold_data;
    hold_valid_n = hold_valid;
    case (state)
      IDLE: begin
        if (accept) begin
          sr_n    = Din;
          cnt_n   = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt != LAST) begin
          sr_n  = sr_shifted;
          cnt_n = cnt + 1'b1;
          if (accept) begin
            hold_data_n  = Din;
            hold_valid_n = 1'b1;
          end
        end else if (hold_valid) begin
          // Buffered word goes first; in_ready is low, so no accept here.
          sr_n         = hold_data;
          cnt_n        = '0;
          hold_valid_n = 1'b0;
        end else if (accept) begin
          // Empty buffer: a word arriving on the last bit loads directly.
          sr_n  = Din;
          cnt_n = '0;
        end else begin
          sr_n    = '0;
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are derived from the next-state values so they register in step.
  always_comb begin
    frame_n = (state_n == SHIFT);
    dout_n  = 1'b0;
    if (frame_n) dout_n = MSB_FIRST ? sr_n[N-1] : sr_n[0];
    sof_n   = frame_n && (cnt_n == '0);
    eof_n   = frame_n && (cnt_n == LAST);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sr         <= '0;
      cnt        <= '0;
      hold_data  <= '0;
      hold_valid <= 1'b0;
      Dout       <= 1'b0;
      frame      <= 1'b0;
      sof        <= 1'b0;
      eof        <= 1'b0;
    end else begin
      state      <= state_n;
      sr         <= sr_n;
      cnt        <= cnt_n;
      hold_data  <= hold_data_n;
      hold_valid <= hold_valid_n;
      Dout       <= dout_n;
      frame      <= frame_n;
      sof        <= sof_n;
      eof        <= eof_n;
    end
  end

endmodule
